// File: rtl/operand_encoder_pkg.sv
// rtl/operand_encoder_pkg.sv - shared types, register ids and stage sequencing helpers for operand_encoder
package operand_encoder_pkg;

  typedef enum logic [4:0] {
    MODE_NONE   = 5'd0,
    MODE_EV     = 5'd1,
    MODE_EV_GV  = 5'd2,
    MODE_GV_EV  = 5'd3,
    MODE_GV_M   = 5'd4,
    MODE_EV_IB  = 5'd5,
    MODE_EV_IZ  = 5'd6,
    MODE_RAX_IZ = 5'd7,
    MODE_RN_IV  = 5'd8,
    MODE_JB     = 5'd9,
    MODE_JZ     = 5'd10
  } opmode_t;

  localparam logic [7:0] REG_NONE = 8'h00;
  localparam logic [7:0] REG_RIP  = 8'h10;
  localparam logic [7:0] REG_RIMM = 8'h11;
  localparam logic [7:0] REG_RSP  = 8'h84;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MODRM = 3'd1,
    S_SIB   = 3'd2,
    S_DISP  = 3'd3,
    S_IMM   = 3'd4
  } enc_state_t;

  typedef struct packed {
    logic       err;
    logic       has_modrm;
    logic [7:0] modrm;
    logic       has_sib;
    logic [7:0] sib;
    logic [2:0] disp_len;
    logic [3:0] imm_len;
    logic [7:0] rex;
  } enc_plan_t;

  function automatic logic fits_s8(logic [31:0] v);
    return (v[31:7] == 25'h0) || (v[31:7] == {25{1'b1}});
  endfunction

  function automatic logic [3:0] stage_len(enc_state_t s, enc_plan_t p);
    case (s)
      S_MODRM, S_SIB: return 4'd1;
      S_DISP:         return {1'b0, p.disp_len};
      S_IMM:          return p.imm_len;
      default:        return 4'd0;
    endcase
  endfunction

  // Next present stage after s; absent stages are skipped, S_IDLE means nothing left.
  function automatic enc_state_t stage_after(enc_state_t s, enc_plan_t p);
    enc_state_t n;
    n = S_IDLE;
    if (s == S_IDLE && p.has_modrm)
      n = S_MODRM;
    else if ((s == S_IDLE || s == S_MODRM) && p.has_sib)
      n = S_SIB;
    else if (s != S_DISP && s != S_IMM && p.disp_len != 3'd0)
      n = S_DISP;
    else if (s != S_IMM && p.imm_len != 4'd0)
      n = S_IMM;
    return n;
  endfunction

endpackage

// File: rtl/operand_enc_plan.sv
// rtl/operand_enc_plan.sv - combinational descriptor to enc_plan_t; OPENC_DISP_COMPRESS_EN selects short displacements
module operand_enc_plan
  import operand_encoder_pkg::*;
#(
  parameter int MODE_W = 5,
  parameter int REG_W  = 8
) (
  input  logic [MODE_W-1:0] mode,
  input  logic              rex_w,
  input  logic              opsize16,
  input  logic [2:0]        ext,
  input  logic              rm_type,
  input  logic [REG_W-1:0]  base,
  input  logic [REG_W-1:0]  index,
  input  logic [1:0]        scale,
  input  logic [31:0]       disp,
  input  logic [REG_W-1:0]  reg_op,
  output enc_plan_t         plan
);

  logic       is_gv, has_modrm, base_none, base_rip, idx_none, need_sib;
  logic       rr, rx, rb, has_sib;
  logic [1:0] md;
  logic [2:0] rm_f, reg_f, disp_len;
  logic [3:0] imm_len;
  logic [7:0] sib;
  logic       unused_reg;

  assign unused_reg = ^reg_op[REG_W-1:4];

`ifndef OPENC_DISP_COMPRESS_EN
  logic unused_disp;
  assign unused_disp = ^disp;
`endif

  assign is_gv     = mode inside {MODE_EV_GV, MODE_GV_EV, MODE_GV_M};
  assign has_modrm = is_gv || (mode inside {MODE_EV, MODE_EV_IB, MODE_EV_IZ});
  assign base_none = (base == REG_W'(REG_NONE));
  assign base_rip  = (base == REG_W'(REG_RIP));
  assign idx_none  = (index == REG_W'(REG_NONE));
  assign need_sib  = !idx_none || base_none || (base[2:0] == 3'b100);
  assign reg_f     = is_gv ? reg_op[2:0] : ext;
  assign rr        = is_gv & reg_op[3];

  always_comb begin
    md       = 2'b11;
    rm_f     = base[2:0];
    has_sib  = 1'b0;
    sib      = 8'h00;
    disp_len = 3'd0;
    rx       = 1'b0;
    rb       = 1'b0;
    if (!has_modrm) begin
      rb = (mode == MODE_RN_IV) & base[3];
    end else if (!rm_type) begin
      rb = base[3];
    end else if (base_rip) begin
      md       = 2'b00;
      rm_f     = 3'b101;
      disp_len = 3'd4;
    end else begin
      rm_f    = need_sib ? 3'b100 : base[2:0];
      has_sib = need_sib;
      sib     = {scale, idx_none ? 3'b100 : index[2:0], base_none ? 3'b101 : base[2:0]};
      rx      = !idx_none & index[3];
      rb      = !base_none & base[3];
      // No base means the SIB base field 101 selects a bare disp32 under mod 00.
      if (base_none) begin
        md       = 2'b00;
        disp_len = 3'd4;
`ifdef OPENC_DISP_COMPRESS_EN
      end else if (disp == 32'h0 && base[2:0] != 3'b101) begin
        md       = 2'b00;
        disp_len = 3'd0;
      end else if (fits_s8(disp)) begin
        md       = 2'b01;
        disp_len = 3'd1;
`endif
      end else begin
        md       = 2'b10;
        disp_len = 3'd4;
      end
    end
  end

  always_comb begin
    imm_len = 4'd0;
    case (mode)
      MODE_EV_IB, MODE_JB:              imm_len = 4'd1;
      MODE_EV_IZ, MODE_RAX_IZ, MODE_JZ: imm_len = 4'd4;
      MODE_RN_IV:                       imm_len = rex_w ? 4'd8 : (opsize16 ? 4'd2 : 4'd4);
      default:                          imm_len = 4'd0;
    endcase
  end

  always_comb begin
    plan           = '0;
    plan.err       = (mode > MODE_JZ)
                   || (has_modrm && rm_type && index == REG_W'(REG_RSP))
                   || (mode == MODE_GV_M && !rm_type);
    plan.has_modrm = has_modrm;
    plan.modrm     = {md, reg_f, rm_f};
    plan.has_sib   = has_sib;
    plan.sib       = sib;
    plan.disp_len  = disp_len;
    plan.imm_len   = imm_len;
    plan.rex       = {4'b0100, rex_w, rr, rx, rb};
  end

endmodule

// File: rtl/operand_encoder.sv
// rtl/operand_encoder.sv - serialises ModRM/SIB/disp/imm bytes of one descriptor; OPENC_DISP_COMPRESS_EN enables disp8/no-disp forms
module operand_encoder
  import operand_encoder_pkg::*;
#(
  parameter int MODE_W = 5,
  parameter int REG_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [7:0]        in_rex,
  input  logic              in_opsize16,
  input  logic [2:0]        in_ext,
  input  logic              in_rm_type,
  input  logic [REG_W-1:0]  in_base,
  input  logic [REG_W-1:0]  in_index,
  input  logic [1:0]        in_scale,
  input  logic [31:0]       in_disp,
  input  logic [REG_W-1:0]  in_reg,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [7:0]        rex_out,
  output logic              done,
  output logic              err
);

  enc_plan_t  plan, plan_q;
  enc_state_t state, first, after;
  logic [3:0]  cnt;
  logic [31:0] disp_q;
  logic [63:0] imm_q;
  logic        unused_bits;

  assign unused_bits = ^{in_rex[7:4], in_rex[2:0], plan_q.err, plan_q.rex};

  operand_enc_plan #(.MODE_W(MODE_W), .REG_W(REG_W)) u_plan (
    .mode     (in_mode),
    .rex_w    (in_rex[3]),
    .opsize16 (in_opsize16),
    .ext      (in_ext),
    .rm_type  (in_rm_type),
    .base     (in_base),
    .index    (in_index),
    .scale    (in_scale),
    .disp     (in_disp),
    .reg_op   (in_reg),
    .plan     (plan)
  );

  function automatic logic [7:0] stage_byte(enc_state_t s, enc_plan_t p, logic [31:0] d, logic [63:0] i);
    case (s)
      S_MODRM: return p.modrm;
      S_SIB:   return p.sib;
      S_DISP:  return d[7:0];
      S_IMM:   return i[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic is_final(enc_state_t s, enc_plan_t p);
    return (stage_len(s, p) == 4'd1) && (stage_after(s, p) == S_IDLE);
  endfunction

  assign in_ready = (state == S_IDLE);
  assign first    = stage_after(S_IDLE, plan);
  assign after    = stage_after(state, plan_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_byte  <= 8'h00;
      done      <= 1'b0;
      err       <= 1'b0;
      rex_out   <= 8'h40;
      plan_q    <= '0;
      disp_q    <= 32'h0;
      imm_q     <= 64'h0;
      cnt       <= 4'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            rex_out <= plan.rex;
            plan_q  <= plan;
            disp_q  <= in_disp;
            imm_q   <= in_imm;
            if (plan.err) begin
              err <= 1'b1;
            end else if (first == S_IDLE) begin
              done <= 1'b1;
            end else begin
              state     <= first;
              out_valid <= 1'b1;
              out_byte  <= stage_byte(first, plan, in_disp, in_imm);
              out_last  <= is_final(first, plan);
              cnt       <= stage_len(first, plan);
            end
          end
        end
        default: begin
          if (out_ready) begin
            // Multi-byte fields shift right so the next little-endian byte sits at [15:8].
            if (cnt > 4'd1) begin
              cnt      <= cnt - 4'd1;
              out_last <= (cnt == 4'd2) && (after == S_IDLE);
              if (state == S_DISP) begin
                disp_q   <= disp_q >> 8;
                out_byte <= disp_q[15:8];
              end else begin
                imm_q    <= imm_q >> 8;
                out_byte <= imm_q[15:8];
              end
            end else if (after == S_IDLE) begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              state    <= after;
              cnt      <= stage_len(after, plan_q);
              out_byte <= stage_byte(after, plan_q, disp_q, imm_q);
              out_last <= is_final(after, plan_q);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_encoder.sv
// tb/tb_operand_encoder.sv - randomized and directed self-checking bench for operand_encoder
module tb_operand_encoder;
  import operand_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_mode;
  logic [7:0]  in_rex;
  logic        in_opsize16;
  logic [2:0]  in_ext;
  logic        in_rm_type;
  logic [7:0]  in_base, in_index, in_reg;
  logic [1:0]  in_scale;
  logic [31:0] in_disp;
  logic [63:0] in_imm;
  logic        out_valid, out_ready, out_last, done, err;
  logic [7:0]  out_byte, rex_out;

  always #5 clk = ~clk;

  operand_encoder dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_rex(in_rex), .in_opsize16(in_opsize16), .in_ext(in_ext),
    .in_rm_type(in_rm_type), .in_base(in_base), .in_index(in_index), .in_scale(in_scale),
    .in_disp(in_disp), .in_reg(in_reg), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last), .rex_out(rex_out),
    .done(done), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  mode;
    logic        w;
    logic        op16;
    logic [2:0]  ext;
    logic        rm_type;
    logic [7:0]  base;
    logic [7:0]  index;
    logic [1:0]  scale;
    logic [31:0] disp;
    logic [7:0]  rg;
    logic [63:0] imm;
  } desc_t;

  logic [7:0] exp_q[$];
  logic [7:0] exp_rex;
  bit         exp_err;

  function automatic desc_t mk(input logic [4:0] mode, input logic rm_type, input logic [7:0] base,
                               input logic [31:0] disp, input logic [7:0] rg, input logic [63:0] imm);
    desc_t d;
    d.mode = mode; d.w = 1'b0; d.op16 = 1'b0; d.ext = 3'd0; d.rm_type = rm_type;
    d.base = base; d.index = REG_NONE; d.scale = 2'd0; d.disp = disp; d.rg = rg; d.imm = imm;
    return d;
  endfunction

  task automatic push_le(input logic [63:0] v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(8'(v >> (8 * k)));
  endtask

  // Reference: builds the x86 byte sequence directly from the encoding rules.
  task automatic ref_model(input desc_t d);
    int m, reg_f, rr, xx, bb, md, dl, il;
    bit gv, has_modrm, bnone, inone, use_sib;
    exp_q.delete();
    m = int'(d.mode);
    gv = (m == MODE_EV_GV) || (m == MODE_GV_EV) || (m == MODE_GV_M);
    has_modrm = gv || (m == MODE_EV) || (m == MODE_EV_IB) || (m == MODE_EV_IZ);
    exp_err = (m > 10) || (has_modrm && d.rm_type && d.index == 8'h84) || (m == MODE_GV_M && !d.rm_type);
    rr = 0; xx = 0; bb = 0;
    if (has_modrm) begin
      reg_f = gv ? int'(d.rg % 8) : int'(d.ext);
      rr = gv ? int'((d.rg >> 3) & 1) : 0;
      if (!d.rm_type) begin
        exp_q.push_back(8'(192 + reg_f * 8 + int'(d.base % 8)));
        bb = int'((d.base >> 3) & 1);
      end else if (d.base == REG_RIP) begin
        exp_q.push_back(8'(reg_f * 8 + 5));
        push_le(64'(d.disp), 4);
      end else begin
        bnone = (d.base == 8'h00);
        inone = (d.index == 8'h00);
        use_sib = !inone || bnone || (d.base % 8 == 4);
        if (bnone) begin md = 0; dl = 4; end
`ifdef OPENC_DISP_COMPRESS_EN
        else if (d.disp == 0 && d.base % 8 != 5) begin md = 0; dl = 0; end
        else if ($signed(d.disp) >= -128 && $signed(d.disp) <= 127) begin md = 1; dl = 1; end
`endif
        else begin md = 2; dl = 4; end
        exp_q.push_back(8'(md * 64 + reg_f * 8 + (use_sib ? 4 : int'(d.base % 8))));
        if (use_sib)
          exp_q.push_back(8'(int'(d.scale) * 64 + (inone ? 4 : int'(d.index % 8)) * 8 + (bnone ? 5 : int'(d.base % 8))));
        push_le(64'(d.disp), dl);
        xx = inone ? 0 : int'((d.index >> 3) & 1);
        bb = bnone ? 0 : int'((d.base >> 3) & 1);
      end
    end else if (m == MODE_RN_IV) begin
      bb = int'((d.base >> 3) & 1);
    end
    case (m)
      MODE_EV_IB, MODE_JB: il = 1;
      MODE_EV_IZ, MODE_RAX_IZ, MODE_JZ: il = 4;
      MODE_RN_IV: il = d.w ? 8 : (d.op16 ? 2 : 4);
      default: il = 0;
    endcase
    if (!has_modrm && m > 10) il = 0;
    push_le(d.imm, il);
    exp_rex = 8'(64 + int'(d.w) * 8 + rr * 4 + xx * 2 + bb);
  endtask

  task automatic drive(input desc_t d);
    @(negedge clk);
    check("in_ready idle", in_ready, 1'b1);
    in_mode = d.mode; in_rex = {4'b0100, d.w, 3'b000}; in_opsize16 = d.op16; in_ext = d.ext;
    in_rm_type = d.rm_type; in_base = d.base; in_index = d.index; in_scale = d.scale;
    in_disp = d.disp; in_reg = d.rg; in_imm = d.imm;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // stall_mode: 0 always ready, 1 random backpressure, 2 hold ready low 3 cycles on the third byte.
  task automatic run(input desc_t d, input int stall_mode, input bit use_model);
    int idx, n, budget, stall;
    if (use_model) ref_model(d);
    drive(d);
    n = exp_q.size();
    if (exp_err) begin
      @(negedge clk);
      check("err pulse", err, 1'b1);
      check("err no valid", out_valid, 1'b0);
      check("err no done", done, 1'b0);
    end else if (n == 0) begin
      @(negedge clk);
      check("zero-byte done", done, 1'b1);
      check("zero-byte no valid", out_valid, 1'b0);
      check("zero-byte rex", rex_out, exp_rex);
    end else begin
      idx = 0; budget = 0; stall = 3;
      while (idx < n) begin
        @(negedge clk);
        if (budget++ > 100) begin
          check("byte timeout", idx, n);
          break;
        end
        if (budget == 1) begin
          check("rex_out", rex_out, exp_rex);
          check("in_ready busy", in_ready, 1'b0);
        end
        check("out_valid", out_valid, 1'b1);
        check($sformatf("byte%0d", idx), out_byte, exp_q[idx]);
        check($sformatf("last%0d", idx), out_last, idx == n - 1);
        check("no early done", done, 1'b0);
        if (stall_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else if (stall_mode == 2 && idx == 2 && stall > 0) begin out_ready = 1'b0; stall--; end
        else out_ready = 1'b1;
        if (out_ready && out_valid) idx++;
      end
      @(negedge clk);
      out_ready = 1'b1;
      check("done pulse", done, 1'b1);
      check("idle after last", out_valid, 1'b0);
    end
  endtask

  desc_t d;
  int    r;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = '0; in_rex = 8'h40; in_opsize16 = 1'b0; in_ext = '0; in_rm_type = 1'b0;
    in_base = '0; in_index = '0; in_scale = '0; in_disp = '0; in_reg = '0; in_imm = '0;
    #12;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_byte", out_byte, 8'h00);
    check("reset out_last", out_last, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err", err, 1'b0);
    check("reset rex_out", rex_out, 8'h40);
    @(negedge clk);
    reset_n = 1'b1;

    exp_err = 0;
    d = mk(MODE_EV_GV, 1'b0, 8'h83, 32'h0, 8'h82, 64'h0);
    exp_q = '{8'hD3}; exp_rex = 8'h40;
    run(d, 0, 0);

    d = mk(MODE_GV_EV, 1'b1, 8'h84, 32'h8, 8'h80, 64'h0);
`ifdef OPENC_DISP_COMPRESS_EN
    exp_q = '{8'h44, 8'h24, 8'h08};
`else
    exp_q = '{8'h84, 8'h24, 8'h08, 8'h00, 8'h00, 8'h00};
`endif
    exp_rex = 8'h40;
    run(d, 0, 0);

    d = mk(MODE_EV_IZ, 1'b1, REG_RIP, 32'h12345678, 8'h80, 64'hDEADBEEF);
    exp_q = '{8'h05, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE}; exp_rex = 8'h40;
    run(d, 0, 0);

    d = mk(MODE_GV_EV, 1'b1, 8'h85, 32'h0, 8'h81, 64'h0);
`ifdef OPENC_DISP_COMPRESS_EN
    exp_q = '{8'h4D, 8'h00};
`else
    exp_q = '{8'h8D, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    exp_rex = 8'h40;
    run(d, 0, 0);
    d.base = 8'h8D;
    exp_rex = 8'h41;
    run(d, 0, 0);

    d = mk(MODE_RN_IV, 1'b0, 8'h80, 32'h0, 8'h80, 64'h1122334455667788);
    d.w = 1'b1;
    exp_q = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}; exp_rex = 8'h48;
    run(d, 2, 0);

    d = mk(MODE_NONE, 1'b0, 8'h80, 32'h0, 8'h80, 64'h0);
    exp_q.delete(); exp_rex = 8'h40;
    run(d, 0, 0);

    exp_err = 1;
    d = mk(MODE_GV_EV, 1'b1, 8'h83, 32'h10, 8'h80, 64'h0);
    d.index = 8'h84;
    run(d, 0, 0);
    d = mk(MODE_GV_M, 1'b0, 8'h83, 32'h0, 8'h80, 64'h0);
    run(d, 0, 0);
    d = mk(5'd31, 1'b0, 8'h83, 32'h0, 8'h80, 64'h0);
    run(d, 0, 0);
    exp_err = 0;

    d = mk(MODE_EV_IZ, 1'b1, REG_RIP, 32'h12345678, 8'h80, 64'hDEADBEEF);
    drive(d);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 1'b0);
    check("async reset out_last", out_last, 1'b0);
    check("async reset rex_out", rex_out, 8'h40);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready after reset", in_ready, 1'b1);
    check("idle after reset", out_valid, 1'b0);

    for (int i = 0; i < 250; i++) begin
      d.mode = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(11, 31)) : 5'($urandom_range(0, 10));
      d.w = 1'($urandom_range(0, 1));
      d.op16 = 1'($urandom_range(0, 1));
      d.ext = 3'($urandom_range(0, 7));
      d.rm_type = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      d.base = (r == 0) ? REG_NONE : (r == 1) ? REG_RIP : 8'(8'h80 | $urandom_range(0, 15));
      if (!d.rm_type) d.base = 8'(8'h80 | $urandom_range(0, 15));
      d.index = ($urandom_range(0, 1) == 0) ? REG_NONE : 8'(8'h80 | $urandom_range(0, 15));
      d.scale = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 2);
      d.disp = (r == 0) ? 32'h0 : (r == 1) ? 32'($signed(8'($urandom_range(0, 255)))) : 32'($urandom());
      d.rg = 8'(8'h80 | $urandom_range(0, 15));
      d.imm = {32'($urandom()), 32'($urandom())};
      run(d, $urandom_range(0, 1), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
